// File: rtl/ascon_decrypt_fsm_if.sv
// Handshake and control bundle between the ASCON-128 decryption controller
// and its permutation datapath.
// Optional macro ASCON_DEC_ABORT_EN adds the abort_i request line.
interface ascon_decrypt_fsm_if;
  logic       start_i;
  logic       data_valid_i;
  logic       tag_match_i;
`ifdef ASCON_DEC_ABORT_EN
  logic       abort_i;
`endif
  logic       data_select_o;
  logic       en_xor_key_beg_o;
  logic       en_xor_data_beg_o;
  logic       en_replace_rate_o;
  logic       en_xor_key_end_o;
  logic       en_xor_lsb_end_o;
  logic       en_reg_state_o;
  logic [3:0] round_o;
  logic       plain_valid_o;
  logic       tag_ok_o;
  logic       auth_fail_o;
  logic       end_o;
  logic       busy_o;

  // controller side
  modport slave (
`ifdef ASCON_DEC_ABORT_EN
    input  abort_i,
`endif
    input  start_i, data_valid_i, tag_match_i,
    output data_select_o, en_xor_key_beg_o, en_xor_data_beg_o,
    output en_replace_rate_o, en_xor_key_end_o, en_xor_lsb_end_o,
    output en_reg_state_o, round_o, plain_valid_o, tag_ok_o,
    output auth_fail_o, end_o, busy_o
  );

  // requester / datapath side
  modport master (
`ifdef ASCON_DEC_ABORT_EN
    output abort_i,
`endif
    output start_i, data_valid_i, tag_match_i,
    input  data_select_o, en_xor_key_beg_o, en_xor_data_beg_o,
    input  en_replace_rate_o, en_xor_key_end_o, en_xor_lsb_end_o,
    input  en_reg_state_o, round_o, plain_valid_o, tag_ok_o,
    input  auth_fail_o, end_o, busy_o
  );
endinterface

// File: rtl/ascon_decrypt_fsm.sv
// ASCON-128 decryption sequencer: drives the shared permutation datapath
// through init, AD absorption, ciphertext processing and finalisation, owns
// the round counter and latches the tag comparison result.
// Optional macro ASCON_DEC_ABORT_EN adds abort_i (return to IDLE from any state).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i
// INIT     | p^a on IV||K||N, rounds 0..11, key XOR after last round
// WAIT_AD  | waiting for the next associated-data word
// AD       | p^b over one AD block, rounds 6..11
// WAIT_CT  | waiting for the next ciphertext word
// CT       | p^b over one CT block with rate replace, rounds 6..11
// FINAL    | last CT block + p^a with key XORs, rounds 0..11
// WAIT_TAG | waiting for the received tag to be compared
// DONE     | one-cycle completion pulse
module ascon_decrypt_fsm #(
  parameter int NB_AD = 1,
  parameter int NB_CT = 3
) (
  input logic                clock_i,
  input logic                resetb_i,
  ascon_decrypt_fsm_if.slave bus
);

  localparam int AD_W = $clog2(NB_AD + 1);
  localparam int CT_W = $clog2(NB_CT + 1);
  localparam logic [AD_W-1:0] AD_LAST = AD_W'(NB_AD - 1);
  localparam logic [CT_W-1:0] CT_LAST = CT_W'(NB_CT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_CT, S_CT, S_FINAL, S_WAIT_TAG, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [AD_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [CT_W-1:0] ct_cnt_q, ct_cnt_d;
  logic            tag_ok_q, tag_ok_d;

  // next state, round index, block counters and tag flag
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    ad_cnt_d = ad_cnt_q;
    ct_cnt_d = ct_cnt_q;
    tag_ok_d = tag_ok_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d  = S_INIT;
          round_d  = 4'd0;
          ad_cnt_d = '0;
          ct_cnt_d = '0;
          tag_ok_d = 1'b0;
        end
      end
      S_INIT: begin
        if (round_q == 4'd11) state_d = S_WAIT_AD;
        else                  round_d = round_q + 4'd1;
      end
      S_WAIT_AD: begin
        if (bus.data_valid_i) begin
          state_d = S_AD;
          round_d = 4'd6;
        end
      end
      S_AD: begin
        if (round_q == 4'd11) begin
          ad_cnt_d = ad_cnt_q + AD_W'(1);
          state_d  = (ad_cnt_q == AD_LAST) ? S_WAIT_CT : S_WAIT_AD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_WAIT_CT: begin
        if (bus.data_valid_i) begin
          // the last ciphertext block is folded into finalisation
          if (ct_cnt_q < CT_LAST) begin
            state_d = S_CT;
            round_d = 4'd6;
          end else begin
            state_d = S_FINAL;
            round_d = 4'd0;
          end
        end
      end
      S_CT: begin
        if (round_q == 4'd11) begin
          ct_cnt_d = ct_cnt_q + CT_W'(1);
          state_d  = S_WAIT_CT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_FINAL: begin
        if (round_q == 4'd11) state_d = S_WAIT_TAG;
        else                  round_d = round_q + 4'd1;
      end
      S_WAIT_TAG: begin
        if (bus.data_valid_i) begin
          tag_ok_d = bus.tag_match_i;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
`ifdef ASCON_DEC_ABORT_EN
    // abort overrides every other transition, including start in IDLE
    if (bus.abort_i) begin
      state_d  = S_IDLE;
      round_d  = 4'd0;
      ad_cnt_d = '0;
      ct_cnt_d = '0;
      tag_ok_d = 1'b0;
    end
`endif
  end

  // state registers plus datapath controls decoded one cycle ahead so every output is a flop
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q               <= S_IDLE;
      round_q               <= 4'd0;
      ad_cnt_q              <= '0;
      ct_cnt_q              <= '0;
      tag_ok_q              <= 1'b0;
      bus.data_select_o     <= 1'b1;
      bus.en_xor_key_beg_o  <= 1'b0;
      bus.en_xor_data_beg_o <= 1'b0;
      bus.en_replace_rate_o <= 1'b0;
      bus.en_xor_key_end_o  <= 1'b0;
      bus.en_xor_lsb_end_o  <= 1'b0;
      bus.en_reg_state_o    <= 1'b0;
      bus.plain_valid_o     <= 1'b0;
      bus.auth_fail_o       <= 1'b0;
      bus.end_o             <= 1'b0;
      bus.busy_o            <= 1'b0;
    end else begin
      state_q               <= state_d;
      round_q               <= round_d;
      ad_cnt_q              <= ad_cnt_d;
      ct_cnt_q              <= ct_cnt_d;
      tag_ok_q              <= tag_ok_d;
      bus.data_select_o     <= !(state_d == S_INIT && round_d == 4'd0);
      bus.en_xor_key_beg_o  <= (state_d == S_FINAL && round_d == 4'd0);
      bus.en_xor_data_beg_o <= (state_d == S_AD && round_d == 4'd6);
      bus.en_replace_rate_o <= (state_d == S_CT && round_d == 4'd6) ||
                               (state_d == S_FINAL && round_d == 4'd0);
      bus.en_xor_key_end_o  <= (state_d == S_INIT || state_d == S_FINAL) && round_d == 4'd11;
      // domain separation only after the final AD block
      bus.en_xor_lsb_end_o  <= (state_d == S_AD && round_d == 4'd11 && ad_cnt_d == AD_LAST);
      bus.en_reg_state_o    <= (state_d == S_INIT || state_d == S_AD ||
                                state_d == S_CT   || state_d == S_FINAL);
      bus.plain_valid_o     <= (state_d == S_CT && round_d == 4'd6) ||
                               (state_d == S_FINAL && round_d == 4'd0);
      bus.auth_fail_o       <= (state_d == S_DONE) && !tag_ok_d;
      bus.end_o             <= (state_d == S_DONE);
      bus.busy_o            <= (state_d != S_IDLE);
    end
  end

  assign bus.round_o  = round_q;
  assign bus.tag_ok_o = tag_ok_q;

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// Testbench for ascon_decrypt_fsm: default instance (NB_AD=1, NB_CT=3) driven
// from a scenario table with a per-cycle expected-output queue, plus an
// NB_AD=2/NB_CT=1 instance, a mid-FINAL reset and (with ASCON_DEC_ABORT_EN) abort.
module tb_ascon_decrypt_fsm;

  logic clock_i = 1'b0;
  logic resetb_i;

  always #5 clock_i = ~clock_i;

  ascon_decrypt_fsm_if if0 ();
  ascon_decrypt_fsm_if if1 ();

  ascon_decrypt_fsm u0 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(if0.slave));
  ascon_decrypt_fsm #(.NB_AD(2), .NB_CT(1)) u1 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(if1.slave));

  // bit layout: [15:12] round, 11 data_select, 10 key_beg, 9 data_beg, 8 replace,
  // 7 key_end, 6 lsb_end, 5 reg_state, 4 plain_valid, 3 tag_ok, 2 auth_fail, 1 end, 0 busy
  logic [15:0] s0, s1;
  assign s0 = {if0.round_o, if0.data_select_o, if0.en_xor_key_beg_o, if0.en_xor_data_beg_o,
               if0.en_replace_rate_o, if0.en_xor_key_end_o, if0.en_xor_lsb_end_o,
               if0.en_reg_state_o, if0.plain_valid_o, if0.tag_ok_o, if0.auth_fail_o,
               if0.end_o, if0.busy_o};
  assign s1 = {if1.round_o, if1.data_select_o, if1.en_xor_key_beg_o, if1.en_xor_data_beg_o,
               if1.en_replace_rate_o, if1.en_xor_key_end_o, if1.en_xor_lsb_end_o,
               if1.en_reg_state_o, if1.plain_valid_o, if1.tag_ok_o, if1.auth_fail_o,
               if1.end_o, if1.busy_o};

  localparam logic [15:0] RESET_SNAP = 16'h0800;

  typedef struct {
    logic tm;       // tag_match_i value at the tag cycle
    int   stall;    // cycles data_valid_i is held low in the first WAIT_CT
    logic hold;     // keep start_i high while busy
    int   exp_end;  // cycle of the end_o pulse
    logic exp_tag;  // tag_ok_o after completion
    int   exp_af;   // number of auth_fail_o cycles
  } vec_t;

  vec_t        vt[4];
  logic [31:0] sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp, input logic [15:0] mask);
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act & mask, exp & mask);
    end
  endtask

  // expected outputs of the default instance, cycle c after start accepted, valid always high
  function automatic logic [15:0] exp_snap(input int c, input logic tm);
    logic [3:0] r;
    logic ds, kb, db, rr, ke, le, rs, pv, tk, af, en, bz;
    if (c >= 1 && c <= 12)       r = 4'(c - 1);
    else if (c >= 14 && c <= 19) r = 4'(c - 8);
    else if (c >= 21 && c <= 26) r = 4'(c - 15);
    else if (c >= 28 && c <= 33) r = 4'(c - 22);
    else if (c >= 35 && c <= 46) r = 4'(c - 35);
    else                         r = 4'd11;
    ds = (c != 1);
    kb = (c == 35);
    db = (c == 14);
    rr = (c == 21 || c == 28 || c == 35);
    pv = rr;
    ke = (c == 12 || c == 46);
    le = (c == 19);
    rs = (c >= 1 && c <= 12) || (c >= 14 && c <= 19) || (c >= 21 && c <= 26) ||
         (c >= 28 && c <= 33) || (c >= 35 && c <= 46);
    tk = (c >= 48) ? tm : 1'b0;
    af = (c == 48) && !tm;
    en = (c == 48);
    bz = (c >= 1 && c <= 48);
    return {r, ds, kb, db, rr, ke, le, rs, pv, tk, af, en, bz};
  endfunction

  function automatic logic [15:0] exp_mask(input int c);
    return (c >= 48) ? 16'h0FFF : 16'hFFFF;
  endfunction

  // stalling L cycles in the first WAIT_CT (cycle 20) shifts everything after it by L
  function automatic int map_cyc(input int c, input int L);
    if (c <= 20)     return c;
    if (c <= 20 + L) return 20;
    return c - L;
  endfunction

  task automatic run_scn(input int idx, input vec_t v);
    int          L;
    int          ncyc;
    int          end_cyc;
    int          af_cnt;
    int          m;
    logic [31:0] e;
    L       = v.stall;
    ncyc    = 50 + L;
    end_cyc = -1;
    af_cnt  = 0;
    if0.start_i      = 1'b1;
    if0.data_valid_i = 1'b1;
    if0.tag_match_i  = ~v.tm;
    sb.push_back({exp_mask(1), exp_snap(1, v.tm)});
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL scn%0d c%0d queue_empty got=0 want=1", idx, c);
      end else begin
        e = sb.pop_front();
        check($sformatf("scn%0d c%0d", idx, c), s0, e[15:0], e[31:16]);
      end
      if (if0.end_o && end_cyc < 0) end_cyc = c;
      if (if0.auth_fail_o) af_cnt++;
      m = map_cyc(c, L);
      if0.start_i      = v.hold && (m < 47);
      if0.data_valid_i = !(c >= 20 && c < 20 + L);
      if0.tag_match_i  = (m == 47) ? v.tm : ~v.tm;
      if (c < ncyc) begin
        m = map_cyc(c + 1, L);
        sb.push_back({exp_mask(m), exp_snap(m, v.tm)});
      end
    end
    if0.start_i = 1'b0;
    check($sformatf("scn%0d end_cycle", idx), 16'(end_cyc), 16'(v.exp_end), 16'hFFFF);
    check($sformatf("scn%0d tag_ok", idx), {15'd0, if0.tag_ok_o}, {15'd0, v.exp_tag}, 16'h0001);
    check($sformatf("scn%0d auth_fail_cnt", idx), 16'(af_cnt), 16'(v.exp_af), 16'hFFFF);
  endtask

  initial begin
    vt[0] = '{tm: 1'b1, stall: 0, hold: 1'b0, exp_end: 48, exp_tag: 1'b1, exp_af: 0};
    vt[1] = '{tm: 1'b0, stall: 0, hold: 1'b0, exp_end: 48, exp_tag: 1'b0, exp_af: 1};
    vt[2] = '{tm: 1'b1, stall: 5, hold: 1'b0, exp_end: 53, exp_tag: 1'b1, exp_af: 0};
    vt[3] = '{tm: 1'b0, stall: 3, hold: 1'b1, exp_end: 51, exp_tag: 1'b0, exp_af: 1};

    resetb_i         = 1'b0;
    if0.start_i      = 1'b0;
    if0.data_valid_i = 1'b0;
    if0.tag_match_i  = 1'b0;
    if1.start_i      = 1'b0;
    if1.data_valid_i = 1'b0;
    if1.tag_match_i  = 1'b0;
`ifdef ASCON_DEC_ABORT_EN
    if0.abort_i      = 1'b0;
    if1.abort_i      = 1'b0;
`endif
    repeat (3) @(negedge clock_i);
    check("reset u0", s0, RESET_SNAP, 16'hFFFF);
    check("reset u1", s1, RESET_SNAP, 16'hFFFF);
    resetb_i = 1'b1;
    @(negedge clock_i);
    check("idle u0", s0, RESET_SNAP, 16'hFFFF);

    for (int i = 0; i < 4; i++) begin
      run_scn(i, vt[i]);
      @(negedge clock_i);
    end

    // NB_AD=2, NB_CT=1: AD blocks 14-19 and 21-26, FINAL 28-39, end at 41
    if1.start_i      = 1'b1;
    if1.data_valid_i = 1'b1;
    if1.tag_match_i  = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      logic [15:0] ex;
      logic [15:0] mk;
      @(posedge clock_i);
      @(negedge clock_i);
      if1.start_i = 1'b0;
      ex = {4'd0, 1'b0, (c == 28), (c == 14 || c == 21), (c == 28) ? 1'b1 : 1'b0, 1'b0,
            (c == 26), 1'b0, (c == 28), 1'b0, 1'b0, (c == 41), (c <= 41)};
      mk = (c == 28) ? 16'hF753 : 16'h0753;
      check($sformatf("ad2 c%0d", c), s1, ex, mk);
    end
    check("ad2 tag_ok", {15'd0, if1.tag_ok_o}, 16'd1, 16'h0001);
    if1.data_valid_i = 1'b0;

    // reset during FINAL round 5, then a clean run
    if0.start_i      = 1'b1;
    if0.data_valid_i = 1'b1;
    if0.tag_match_i  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      if0.start_i = 1'b0;
    end
    check("pre-reset final r5", s0, exp_snap(40, 1'b1), 16'hFFFF);
    #2 resetb_i = 1'b0;
    #1 check("async reset mid-final", s0, RESET_SNAP, 16'hFFFF);
    @(negedge clock_i);
    check("held reset", s0, RESET_SNAP, 16'hFFFF);
    resetb_i = 1'b1;
    @(negedge clock_i);
    run_scn(4, vt[0]);

`ifdef ASCON_DEC_ABORT_EN
    // abort together with start in CT: back to IDLE, no completion pulse
    @(negedge clock_i);
    if0.start_i      = 1'b1;
    if0.data_valid_i = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      if0.start_i = 1'b0;
    end
    check("abort pre c22", s0, exp_snap(22, 1'b1), 16'hFFFF);
    if0.abort_i = 1'b1;
    if0.start_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    if0.abort_i      = 1'b0;
    if0.start_i      = 1'b0;
    if0.data_valid_i = 1'b0;
    check("abort idle", s0, RESET_SNAP, 16'h0FFF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      check($sformatf("abort quiet %0d", c), s0, RESET_SNAP, 16'h0FFF);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_decrypt_fsm.md
# ascon_decrypt_fsm

Control FSM for ASCON-128 authenticated decryption. It sequences the shared permutation datapath through four phases: initialisation, associated-data absorption, ciphertext processing, and finalisation. It owns the round counter and verifies the received tag against the computed one. It sits beside the encryption controller, drives the same state-register, XOR and round-constant controls, and adds rate-replace and tag-check control.

## Interface
- NB_AD, 1: number of 64-bit associated-data blocks, ≥1.
- NB_CT, 3: number of 64-bit ciphertext blocks, ≥1; the last block is absorbed in the finalisation phase.

Ports:
- clock_i  in  1  clock.
- resetb_i  in  1  reset, asynchronous, active-low; clock clock_i.
- start_i  in  1  begin a decryption; honoured only in IDLE.
- data_valid_i  in  1  datapath input word (AD, CT or tag) is present this cycle.
- tag_match_i  in  1  datapath comparator: computed tag equals received tag.
- data_select_o  out  1  0 loads IV‖K‖N into the state; 1 selects state feedback.
- en_xor_key_beg_o  out  1  XOR 0‖K before the permutation round.
- en_xor_data_beg_o  out  1  XOR the input block into the rate before the round (AD).
- en_replace_rate_o  out  1  overwrite the rate with the ciphertext before the round (CT).
- en_xor_key_end_o  out  1  XOR 0‖K after the round.
- en_xor_lsb_end_o  out  1  XOR the domain-separation bit after the round.
- en_reg_state_o  out  1  state register load enable.
- round_o  out  4  round index for the round constant.
- plain_valid_o  out  1  plaintext block valid at the datapath output.
- tag_ok_o  out  1  authentication result; sticky until the next start.
- auth_fail_o  out  1  one-cycle pulse with end_o on tag mismatch.
- end_o  out  1  one-cycle done pulse.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, INIT, WAIT_AD, AD, WAIT_CT, CT, FINAL, WAIT_TAG, DONE.
- Every active cycle (INIT, AD, CT, FINAL) applies exactly one permutation round at round_o with en_reg_state_o=1. All other states hold en_reg_state_o=0.
- p^a runs round_o 0→11; p^b runs round_o 6→11. The phase leaves on the cycle in which round_o==11.
- Defaults: data_select_o=1; all other outputs 0.
- IDLE: start_i → INIT, round_o←0. Clears tag_ok_o and the AD/CT block counters.
- INIT: round 0 asserts data_select_o=0; round 11 asserts en_xor_key_end_o. Exits to WAIT_AD.
- WAIT_AD: data_valid_i → AD, round_o←6.
- AD: round 6 asserts en_xor_data_beg_o. Round 11 asserts en_xor_lsb_end_o only on AD block NB_AD. Exits to WAIT_AD, or to WAIT_CT after the last AD block.
- WAIT_CT: data_valid_i → CT (round_o←6) if ct_cnt<NB_CT-1, else → FINAL (round_o←0).
- CT: round 6 asserts en_replace_rate_o and plain_valid_o. Exits to WAIT_CT; ct_cnt increments.
- FINAL: round 0 asserts en_replace_rate_o, plain_valid_o and en_xor_key_beg_o; round 11 asserts en_xor_key_end_o. Exits to WAIT_TAG.
- WAIT_TAG: data_valid_i samples tag_match_i into tag_ok_o, then → DONE.
- DONE: end_o=1; auth_fail_o=~tag_ok_o. Exits to IDLE.
- Counter widths are clog2(N+1). Neither counter wraps, because both are cleared at start.

## Timing
- Reset: state IDLE, round_o=0, counters 0, data_select_o=1, all other outputs 0.
- All outputs are decoded from registered state/round_o; no input→output combinational path.
- start_i accepted at edge 0 → INIT occupies cycles 1–12.
- Each WAIT state lasts ≥1 cycle even when data_valid_i is held high.
- data_valid_i is ignored outside WAIT states; start_i is ignored outside IDLE.
- Defaults with valid held high: WAIT_AD 13, AD 14–19, CT blocks at 21–26 and 28–33, FINAL 35–46, WAIT_TAG 47, end_o at cycle 48.
- Reset asserted mid-operation returns to IDLE immediately with reset values, and tag_ok_o=0.

## Configuration
- ASCON_DEC_ABORT_EN defined: adds the input abort_i (1 bit).
  - abort_i=1 in any state → IDLE next cycle.
  - Counters and tag_ok_o are cleared; end_o and auth_fail_o are not pulsed.
  - abort_i has priority over start_i and over every other transition.
- ASCON_DEC_ABORT_EN undefined: no abort_i port; an operation can only be cancelled by reset.

## Test plan
- Defaults, valid always 1, tag_match_i=1 → plain_valid_o at cycles 21, 28, 35; end_o at 48; tag_ok_o=1; auth_fail_o=0.
- Same as above with tag_match_i=0 at cycle 47 → tag_ok_o=0; auth_fail_o and end_o high only at cycle 48.
- data_valid_i held low for 5 cycles in WAIT_CT → en_reg_state_o=0 and round_o stable throughout; processing resumes with round_o=6.
- NB_AD=2, NB_CT=1 → en_xor_lsb_end_o asserted only on the second AD block; WAIT_CT goes directly to FINAL with en_xor_key_beg_o at round 0.
- resetb_i pulsed low during FINAL round 5 → IDLE, round_o=0, busy_o=0; a following start completes normally.
- With ASCON_DEC_ABORT_EN, abort_i and start_i both high in CT → IDLE next cycle; no end_o pulse.
